// File: rtl/seq_scan_ctrl.sv
// Serial 4-bit pattern scanner: accepts a 16-bit word, shifts it out MSB first
// through a Mealy detector and reports the match count and first match position.
module seq_scan_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [3:0]  cfg_pattern,
   input  logic        cfg_overlap,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        busy,
   output logic        ser_bit,
   output logic        hit,
   output logic        done,
   output logic [4:0]  match_cnt,
   output logic [4:0]  first_pos
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t      state_r;
   logic [15:0] word_r;
   logic [3:0]  bit_idx_r;
   logic [2:0]  hist_r;      // only the three most recent bits are ever needed
   logic [2:0]  seen_r;
   logic [3:0]  pattern_r;
   logic        overlap_r;
   logic        in_ready_r;
   logic        busy_r;
   logic        done_r;
   logic [4:0]  match_cnt_r;
   logic [4:0]  first_pos_r;

   logic        ser_bit_s;
   logic [3:0]  hist_next_s;
   logic        hit_s;
   logic [2:0]  seen_sat_s;

   // Detector datapath: current bit, next history window and Mealy match
   always_comb begin
      ser_bit_s   = 1'b0;
      hist_next_s = 4'd0;
      hit_s       = 1'b0;
      if (state_r == SCAN) begin
         ser_bit_s   = word_r[4'd15 - bit_idx_r];
         hist_next_s = {hist_r, ser_bit_s};
         hit_s       = (seen_r >= 3'd3) && (hist_next_s == pattern_r);
      end else begin
         ser_bit_s   = 1'b0;
         hist_next_s = 4'd0;
         hit_s       = 1'b0;
      end
      if (seen_r >= 3'd4) begin
         seen_sat_s = 3'd4;
      end else begin
         seen_sat_s = seen_r + 3'd1;
      end
   end

   // Control FSM, configuration registers and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         word_r      <= 16'd0;
         bit_idx_r   <= 4'd0;
         hist_r      <= 3'd0;
         seen_r      <= 3'd0;
         pattern_r   <= 4'b1101;
         overlap_r   <= 1'b1;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         match_cnt_r <= 5'd0;
         first_pos_r <= 5'd31;
      end else begin
         case (state_r)
            IDLE: begin
               if (cfg_we) begin
                  pattern_r <= cfg_pattern;
                  overlap_r <= cfg_overlap;
               end
               if (in_valid) begin
                  word_r      <= in_data;
                  bit_idx_r   <= 4'd0;
                  hist_r      <= 3'd0;
                  seen_r      <= 3'd0;
                  match_cnt_r <= 5'd0;
                  first_pos_r <= 5'd31;
                  in_ready_r  <= 1'b0;
                  busy_r      <= 1'b1;
                  state_r     <= SCAN;
               end
            end
            SCAN: begin
               if (hit_s) begin
                  match_cnt_r <= match_cnt_r + 5'd1;
                  if (first_pos_r == 5'd31) begin
                     first_pos_r <= {1'b0, bit_idx_r};
                  end
                  // Non-overlapping mode needs four fresh bits after a match
                  if (overlap_r) begin
                     hist_r <= hist_next_s[2:0];
                     seen_r <= seen_sat_s;
                  end else begin
                     hist_r <= 3'd0;
                     seen_r <= 3'd0;
                  end
               end else begin
                  hist_r <= hist_next_s[2:0];
                  seen_r <= seen_sat_s;
               end
               if (bit_idx_r == 4'd15) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= REPORT;
               end else begin
                  bit_idx_r <= bit_idx_r + 4'd1;
               end
            end
            REPORT: begin
               done_r     <= 1'b0;
               in_ready_r <= 1'b1;
               state_r    <= IDLE;
            end
            default: begin
               busy_r     <= 1'b0;
               done_r     <= 1'b0;
               in_ready_r <= 1'b1;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign ser_bit   = ser_bit_s;
   assign hit       = hit_s;
   assign match_cnt = match_cnt_r;
   assign first_pos = first_pos_r;

endmodule
